// File: rtl/nibser_pkg.sv
// ----------------------------------------------------------------------------
// nibser_pkg
// Shared definitions for the nibble-serial adder controller.
//   NIB_W   : width of one adder slice (one nibble)
//   state_e : controller state encoding (IDLE / RUN / DONE)
// No ports (package).
// ----------------------------------------------------------------------------
package nibser_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : nibser_pkg

// File: rtl/nibble_adder4.sv
// ----------------------------------------------------------------------------
// nibble_adder4
// Purely combinational 4-bit ripple-carry adder slice made of four full
// adders. The controller reuses this one slice for every nibble.
// Ports:
//   a[3:0], b[3:0] : slice operands
//   ci             : slice carry-in
//   s[3:0]         : slice sum
//   cout           : slice carry-out
// ----------------------------------------------------------------------------
module nibble_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       cout
);

  // c[i] is the carry into bit i; c[4] leaves the slice.
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule : nibble_adder4

// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl
// Adds two W-bit operands (W = 4*NIBBLES) by time-sharing one 4-bit ripple
// slice, one nibble per clock, least significant nibble first. The carry out
// of each nibble is registered and becomes the carry into the next one.
//
// Handshake: start is accepted in IDLE or DONE; busy is high for NIBBLES
// cycles, then done pulses for one cycle. s/co are valid from done onward and
// held until the next accepted start.
//
// Optional build macro NIBSER_SUB_EN adds a 'sub' input: when sub=1 at start,
// B is latched inverted and the initial carry is forced to 1, so s = A-B
// (mod 2^W) and co=1 means no borrow.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request pulse
//   a, b [W]   : operands, sampled on accepted start
//   ci         : initial carry-in, sampled on accepted start
//   sub        : (NIBSER_SUB_EN only) subtract select, sampled on start
//   s [W]      : sum register
//   co         : carry out of the most significant nibble
//   busy       : nibbles being processed
//   done       : one-cycle pulse when s/co become valid
// ----------------------------------------------------------------------------
module nibble_serial_add_ctrl
  import nibser_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
`ifdef NIBSER_SUB_EN
  input  logic                   sub,
`endif
  output logic [4*NIBBLES-1:0]   s,
  output logic                   co,
  output logic                   busy,
  output logic                   done
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [W-1:0]     a_q;       // shifts right one nibble per RUN cycle
  logic [W-1:0]     b_q;
  logic             carry_q;   // carry into the current nibble
  logic [IDX_W-1:0] idx_q;     // nibble currently being added
  logic [W-1:0]     s_q;
  logic             co_q;

  // Control decoded from the FSM
  logic accept;    // latch operands this edge
  logic step;      // process one nibble this edge
  logic last;      // current nibble is the most significant one

  // Operand/carry values as latched on start (B inverted when subtracting)
  logic [W-1:0] b_load;
  logic         ci_load;

`ifdef NIBSER_SUB_EN
  assign b_load  = sub ? ~b : b;
  assign ci_load = sub ? 1'b1 : ci;
`else
  assign b_load  = b;
  assign ci_load = ci;
`endif

  // --------------------------------------------------------------------------
  // Shared adder slice: always looks at the low nibble of the shift registers
  // --------------------------------------------------------------------------
  logic [NIB_W-1:0] slice_s;
  logic             slice_co;

  nibble_adder4 u_slice (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .ci   (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  assign last = (idx_q == IDX_W'(NIBBLES - 1));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here
        step = 1'b1;
        if (last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Accepting start here gives back-to-back operation
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // NOTE: the operand/result registers are ordinary flops, not a memory, so
  // they are all reset; an abort mid-operation must leave s and co at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else if (accept) begin
      // s and co are left alone so the previous result stays visible
      a_q     <= a;
      b_q     <= b_load;
      carry_q <= ci_load;
      idx_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> NIB_W;
      b_q     <= b_q >> NIB_W;
      carry_q <= slice_co;
      idx_q   <= idx_q + 1'b1;
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDX_W'(i)) begin
          s_q[i*NIB_W +: NIB_W] <= slice_s;
        end
      end
      if (last) begin
        co_q <= slice_co;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s    = s_q;
  assign co   = co_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule : nibble_serial_add_ctrl

// File: tb/tb_nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4). A cycle-level
// transaction model predicts busy/done/s/co from plain arithmetic; a compare
// process checks the DUT against it on every falling edge. Directed tests add
// literal expectations for each result and busy-cycle count.
// Build with NIBSER_SUB_EN defined to also exercise subtraction.
// ----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
`ifdef NIBSER_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] s;
  logic         co;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef NIBSER_SUB_EN
    .sub   (sub),
`endif
    .s     (s),
    .co    (co),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction model: a request is accepted whenever no operation is in
  // flight; the result is the full-width sum, appearing NIBBLES edges later.
  // --------------------------------------------------------------------------
  int           m_left;     // busy cycles still to come
  logic         m_done;
  logic [W:0]   m_pending;  // {carry, sum} of the operation in flight
  logic [W-1:0] m_s;
  logic         m_co;
  logic         m_valid;    // s is defined (not mid-computation)

  function automatic logic [W:0] model_sum(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left    <= 0;
      m_done    <= 1'b0;
      m_pending <= '0;
      m_s       <= '0;
      m_co      <= 1'b0;
      m_valid   <= 1'b1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done  <= 1'b1;
        m_s     <= m_pending[W-1:0];
        m_co    <= m_pending[W];
        m_valid <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left  <= NIBBLES;
        m_valid <= 1'b0;
`ifdef NIBSER_SUB_EN
        m_pending <= model_sum(a, b, ci, sub);
`else
        m_pending <= model_sum(a, b, ci, 1'b0);
`endif
      end
    end
  end

  // Compare process: outputs sampled on the falling edge
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
    check("co",   32'(co),   32'(m_co));
    if (m_valid) check("s", 32'(s), 32'(m_s));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. All are entered and left 1 time unit after a rising edge.
  // --------------------------------------------------------------------------
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic civ, input logic sbv);
    a     = av;
    b     = bv;
    ci    = civ;
`ifdef NIBSER_SUB_EN
    sub   = sbv;
`else
    if (sbv) $display("note: sub requested without subtract support");
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: they must not matter during RUN
    a  = ~av;
    b  = ~bv;
    ci = ~civ;
  endtask

  // Waits for done (bounded), counting remaining busy cycles; returns in the
  // done cycle so a back-to-back start can follow immediately.
  task automatic wait_done(input string name, input logic [W-1:0] exp_s,
                           input logic exp_co, input int exp_busy);
    int nbusy = 0;
    int guard = 0;
    while (!done && guard < 3 * NIBBLES) begin
      if (busy) nbusy++;
      guard++;
      @(posedge clk); #1;
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    check({name, "_s"}, 32'(s), 32'(exp_s));
    check({name, "_co"}, 32'(co), 32'(exp_co));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed tests
  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
`ifdef NIBSER_SUB_EN
    sub   = 1'b0;
`endif
    #12;
    check("reset_s",    32'(s),    32'h0);
    check("reset_co",   32'(co),   32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic add
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done("add_basic", 16'h5555, 1'b0, NIBBLES);
    idle_cycles(2);
    check("hold_s", 32'(s), 32'h5555);

    // Carry through every nibble boundary
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("carry_chain", 16'h0000, 1'b1, NIBBLES);
    idle_cycles(1);

    // Reset during RUN cycle 3: co (1 from the previous op) must drop too
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    idle_cycles(2);
    check("mid_co_held", 32'(co), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_s",    32'(s),    32'h0);
    check("abort_co",   32'(co),   32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NIBBLES + 2; i++) begin
      check("abort_no_done", 32'(done), 32'h0);
      @(posedge clk); #1;
    end
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done("after_abort", 16'h3333, 1'b0, NIBBLES);
    idle_cycles(1);

    // Carry-in only, then back-to-back start in the done cycle
    start_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    wait_done("ci_only", 16'h0001, 1'b0, NIBBLES);
    start_op(16'h000F, 16'h0001, 1'b0, 1'b0);
    wait_done("back_to_back", 16'h0010, 1'b0, NIBBLES);
    idle_cycles(1);

    // Second start during RUN cycle 2 is ignored
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    a     = 16'hAAAA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("start_in_run", 16'h0100, 1'b0, NIBBLES - 2);
    idle_cycles(2);

`ifdef NIBSER_SUB_EN
    // Subtraction: borrow, then no borrow (ci ignored when subtracting)
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done("sub_borrow", 16'hFFFE, 1'b0, NIBBLES);
    idle_cycles(1);
    start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_done("sub_no_borrow", 16'h0002, 1'b1, NIBBLES);
    idle_cycles(1);
    start_op(16'h0007, 16'h0005, 1'b1, 1'b0);
    wait_done("sub0_add", 16'h000D, 1'b0, NIBBLES);
    idle_cycles(1);
`endif

    idle_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nibble_serial_add_ctrl
